// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP front end:
//   - tap_state_t : 4-bit TAP controller state, standard IEEE 1149.1 encoding
//   - CAPTURE_PATTERN_DEFAULT : value loaded into the IR shifter in Capture-IR
//   - OPC_* / DR_OPCODES_DEFAULT : default 8-bit opcode table (slice 0 = IDCODE)
//   - is_shift_state() : true in Shift-DR / Shift-IR, where TDO is driven
// ---------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    // Bits [1:0] = 2'b01 as required for IR capture.
    localparam logic [7:0] CAPTURE_PATTERN_DEFAULT = 8'b1111_0101;

    localparam logic [7:0] OPC_IDCODE = 8'h02;
    localparam logic [7:0] OPC_DEBUG  = 8'h03;
    localparam logic [7:0] OPC_SAMPLE = 8'h04;
    localparam logic [7:0] OPC_EXTEST = 8'h08;

    // Slice i (bits [8*i +: 8]) selects DR i.
    localparam logic [31:0] DR_OPCODES_DEFAULT = {OPC_EXTEST, OPC_SAMPLE, OPC_DEBUG, OPC_IDCODE};

    function automatic logic is_shift_state(input tap_state_t s);
        return (s == TAP_SH_DR) || (s == TAP_SH_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// 16-state IEEE 1149.1 TAP controller, advanced on tms at posedge tck.
// Ports:
//   tck_i            : TCK, the only clock
//   trst_i           : synchronous active-low reset, forces Test-Logic-Reset
//   tms_i            : test mode select
//   state_o          : current TAP state
//   st_tlr_o, st_capture_dr_o, st_shift_dr_o, st_update_dr_o, st_run_idle_o
//                    : decoded current-state strobes
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       st_tlr_o,
    output logic       st_capture_dr_o,
    output logic       st_shift_dr_o,
    output logic       st_update_dr_o,
    output logic       st_run_idle_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    // State register
    always_ff @(posedge tck_i) begin
        if (!trst_i) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms_i ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms_i ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms_i ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    // Decoded outputs
    always_comb begin
        state_o         = state_q;
        st_tlr_o        = (state_q == TAP_TLR);
        st_capture_dr_o = (state_q == TAP_CAP_DR);
        st_shift_dr_o   = (state_q == TAP_SH_DR);
        st_update_dr_o  = (state_q == TAP_UPD_DR);
        st_run_idle_o   = (state_q == TAP_RTI);
    end

endmodule

// File: rtl/jtag_tap_ir_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_tap_ir_ctrl
// JTAG TAP front end: TAP controller, IR shifter + active IR, opcode decode
// into one-hot DR selects, built-in BYPASS bit and the TDO mux.
// Ports:
//   tck, trst (sync, active-low), tms, tdi : JTAG pins
//   tdo, tdo_en  : serial out; tdo_en high only in Shift-IR / Shift-DR
//   dr_tdo       : serial outputs of the external DRs
//   dr_sel       : one-hot DR select, zero when BYPASS is selected
//   bypass_sel   : active instruction matches no opcode table entry
//   ir_q         : active instruction
//   st_*         : decoded current-state strobes for the DR blocks
// ---------------------------------------------------------------------------
module jtag_tap_ir_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned                IR_WIDTH        = 8,
    parameter int unsigned                NUM_DR          = 4,
    parameter logic [NUM_DR*IR_WIDTH-1:0] DR_OPCODES      = DR_OPCODES_DEFAULT,
    parameter int unsigned                IDCODE_INDEX    = 0,
    parameter logic [IR_WIDTH-1:0]        CAPTURE_PATTERN = CAPTURE_PATTERN_DEFAULT
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic [NUM_DR-1:0]   dr_tdo,
    output logic [NUM_DR-1:0]   dr_sel,
    output logic                bypass_sel,
    output logic [IR_WIDTH-1:0] ir_q,
    output logic                st_tlr,
    output logic                st_capture_dr,
    output logic                st_shift_dr,
    output logic                st_update_dr,
    output logic                st_run_idle
);

    localparam logic [IR_WIDTH-1:0] RESET_IR  = DR_OPCODES[IDCODE_INDEX*IR_WIDTH +: IR_WIDTH];
    localparam logic [NUM_DR-1:0]   RESET_SEL = NUM_DR'(1) << IDCODE_INDEX;

    tap_state_t state;

    jtag_tap_fsm u_fsm (
        .tck_i           (tck),
        .trst_i          (trst),
        .tms_i           (tms),
        .state_o         (state),
        .st_tlr_o        (st_tlr),
        .st_capture_dr_o (st_capture_dr),
        .st_shift_dr_o   (st_shift_dr),
        .st_update_dr_o  (st_update_dr),
        .st_run_idle_o   (st_run_idle)
    );

    logic [IR_WIDTH-1:0] sh_q, sh_d;
    logic [NUM_DR-1:0]   dr_sel_q;
    logic                bypass_sel_q;
    logic                bypass_q, bypass_d;
    logic [NUM_DR-1:0]   match;
    logic [NUM_DR-1:0]   dec_sel;
    logic                dr_tdo_sel;

    // Compare the shifter (the value about to become active) against every table slice.
    for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_match
        assign match[gi] = (sh_q == DR_OPCODES[gi*IR_WIDTH +: IR_WIDTH]);
    end

    // Isolate the lowest set bit so duplicated opcodes resolve to the lower index.
    assign dec_sel = match & (~match + NUM_DR'(1));

    always_comb begin
        sh_d = sh_q;
        if (state == TAP_CAP_IR) begin
            sh_d = CAPTURE_PATTERN;
        end else if (state == TAP_SH_IR) begin
            sh_d = {tdi, sh_q[IR_WIDTH-1:1]};
        end
    end

    always_comb begin
        bypass_d = bypass_q;
        if (state == TAP_CAP_DR) begin
            bypass_d = 1'b0;
        end else if (state == TAP_SH_DR && bypass_sel_q) begin
            bypass_d = tdi;
        end
    end

    // Being in Test-Logic-Reset resets the datapath just like trst does, so a
    // partially shifted IR can never reach ir_q after a reset.
    always_ff @(posedge tck) begin
        if (!trst || state == TAP_TLR) begin
            sh_q         <= '0;
            ir_q         <= RESET_IR;
            dr_sel_q     <= RESET_SEL;
            bypass_sel_q <= 1'b0;
            bypass_q     <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            bypass_q <= bypass_d;
            // Edge leaving Update-IR: instruction and its decode change together.
            if (state == TAP_UPD_IR) begin
                ir_q         <= sh_q;
                dr_sel_q     <= dec_sel;
                bypass_sel_q <= ~|dec_sel;
            end
        end
    end

    assign dr_sel     = dr_sel_q;
    assign bypass_sel = bypass_sel_q;
    assign dr_tdo_sel = |(dr_tdo & dr_sel_q);

    always_comb begin
        tdo    = 1'b0;
        tdo_en = is_shift_state(state);
        if (state == TAP_SH_IR) begin
            tdo = sh_q[0];
        end else if (state == TAP_SH_DR) begin
            tdo = bypass_sel_q ? bypass_q : dr_tdo_sel;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ir_ctrl.sv
module tb_jtag_tap_ir_ctrl;

    logic       tck;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] dr_tdo;
    logic [3:0] dr_sel;
    logic       bypass_sel;
    logic [7:0] ir_q;
    logic       st_tlr, st_capture_dr, st_shift_dr, st_update_dr, st_run_idle;

    jtag_tap_ir_ctrl dut (
        .tck           (tck),
        .trst          (trst),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_en        (tdo_en),
        .dr_tdo        (dr_tdo),
        .dr_sel        (dr_sel),
        .bypass_sel    (bypass_sel),
        .ir_q          (ir_q),
        .st_tlr        (st_tlr),
        .st_capture_dr (st_capture_dr),
        .st_shift_dr   (st_shift_dr),
        .st_update_dr  (st_update_dr),
        .st_run_idle   (st_run_idle)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    int edge_cnt = 0;
    always @(posedge tck) edge_cnt <= edge_cnt + 1;

    localparam int K_IR = 0, K_SEL = 1, K_BYP = 2, K_TDOEN = 3, K_TDO = 4,
                   K_TLR = 5, K_RTI = 6, K_CAPDR = 7, K_SHDR = 8, K_UPDDR = 9;

    typedef struct {
        int         tag;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t sq[$];   // status expectations, tagged with the edge count they follow
    logic tq[$];   // serial tdo expectations, consumed whenever tdo_en is high

    int checks   = 0;
    int failures = 0;

    logic [7:0] cap_pat = 8'hF5;
    logic [7:0] cur_ir  = 8'h02;
    logic [3:0] cur_sel = 4'b0001;

    function automatic string kname(input int k);
        case (k)
            K_IR:    return "ir_q";
            K_SEL:   return "dr_sel";
            K_BYP:   return "bypass_sel";
            K_TDOEN: return "tdo_en";
            K_TDO:   return "tdo";
            K_TLR:   return "st_tlr";
            K_RTI:   return "st_run_idle";
            K_CAPDR: return "st_capture_dr";
            K_SHDR:  return "st_shift_dr";
            K_UPDDR: return "st_update_dr";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int k);
        case (k)
            K_IR:    return ir_q;
            K_SEL:   return {4'b0, dr_sel};
            K_BYP:   return {7'b0, bypass_sel};
            K_TDOEN: return {7'b0, tdo_en};
            K_TDO:   return {7'b0, tdo};
            K_TLR:   return {7'b0, st_tlr};
            K_RTI:   return {7'b0, st_run_idle};
            K_CAPDR: return {7'b0, st_capture_dr};
            K_SHDR:  return {7'b0, st_shift_dr};
            K_UPDDR: return {7'b0, st_update_dr};
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        logic       exp_bit;
        forever begin
            @(negedge tck);
            while (sq.size() > 0 && sq[0].tag == edge_cnt) begin
                e   = sq.pop_front();
                act = actual(e.kind);
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s edge=%0d actual=%0h required=%0h", kname(e.kind), edge_cnt, act, e.val);
                end else begin
                    $display("ok   %s edge=%0d value=%0h", kname(e.kind), edge_cnt, act);
                end
            end
            if (tdo_en === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin
                    failures++;
                    $display("FAIL tdo_unexpected edge=%0d actual tdo_en=1 required no shift", edge_cnt);
                end else begin
                    exp_bit = tq.pop_front();
                    if (tdo !== exp_bit) begin
                        failures++;
                        $display("FAIL tdo_serial edge=%0d actual=%b required=%b", edge_cnt, tdo, exp_bit);
                    end else begin
                        $display("ok   tdo_serial edge=%0d value=%b", edge_cnt, tdo);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Drive inputs for the next rising edge.
    task automatic tick(input logic t_ms, input logic t_di);
        @(negedge tck);
        #1;
        tms = t_ms;
        tdi = t_di;
    endtask

    // Expectation for the state right after the edge just set up by tick().
    task automatic expect_s(input int k, input logic [7:0] v);
        sq.push_back('{edge_cnt + 1, k, v});
    endtask

    // Full IR scan starting and ending in Run-Test/Idle.
    task automatic ir_scan(input logic [7:0] op, input logic [3:0] sel, input logic byp);
        tick(1'b1, 1'b0);                    // Select-DR
        tick(1'b1, 1'b0);                    // Select-IR
        tick(1'b0, 1'b0);                    // Capture-IR
        tick(1'b0, 1'b0);                    // Shift-IR
        tq.push_back(cap_pat[0]);
        for (int i = 0; i < 8; i++) begin
            tick(i == 7, op[i]);
            if (i < 7) tq.push_back(cap_pat[i+1]);
        end
        expect_s(K_TDOEN, 8'd0);             // Exit1-IR
        tick(1'b1, 1'b0);                    // Update-IR entered: old instruction still active
        expect_s(K_IR, cur_ir);
        expect_s(K_SEL, {4'b0, cur_sel});
        tick(1'b0, 1'b0);                    // leave Update-IR: new instruction active
        expect_s(K_IR, op);
        expect_s(K_SEL, {4'b0, sel});
        expect_s(K_BYP, {7'b0, byp});
        expect_s(K_RTI, 8'd1);
        cur_ir  = op;
        cur_sel = sel;
    endtask

    initial begin : stimulus
        trst   = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        dr_tdo = 4'b1110;

        // Reset held for one edge
        tick(1'b1, 1'b0);
        expect_s(K_TLR, 8'd1);
        expect_s(K_IR, 8'h02);
        expect_s(K_SEL, 8'h01);
        expect_s(K_BYP, 8'd0);
        expect_s(K_TDOEN, 8'd0);
        tick(1'b0, 1'b0);
        trst = 1'b1;
        expect_s(K_RTI, 8'd1);
        expect_s(K_TLR, 8'd0);

        // Into Shift-DR, then five tms=1 edges back to Test-Logic-Reset
        tick(1'b1, 1'b0);                    // Select-DR
        tick(1'b0, 1'b0);                    // Capture-DR
        expect_s(K_CAPDR, 8'd1);
        tick(1'b0, 1'b0);                    // Shift-DR, IDCODE selected, dr_tdo[0]=0
        expect_s(K_SHDR, 8'd1);
        tq.push_back(1'b0);
        tick(1'b1, 1'b0);                    // Exit1-DR
        tick(1'b1, 1'b0);                    // Update-DR
        expect_s(K_UPDDR, 8'd1);
        tick(1'b1, 1'b0);                    // Select-DR
        tick(1'b1, 1'b0);                    // Select-IR
        expect_s(K_TLR, 8'd0);
        tick(1'b1, 1'b0);                    // Test-Logic-Reset
        expect_s(K_TLR, 8'd1);
        expect_s(K_IR, 8'h02);
        tick(1'b0, 1'b0);                    // Run-Test/Idle
        expect_s(K_RTI, 8'd1);

        // Opcode table entries and an unmatched opcode
        ir_scan(8'h03, 4'b0010, 1'b0);
        ir_scan(8'hFF, 4'b0000, 1'b1);

        // BYPASS: tdi 1,0,1 -> tdo 0,1,0
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);  tq.push_back(1'b0);
        tick(1'b0, 1'b1);  tq.push_back(1'b1);
        tick(1'b0, 1'b0);  tq.push_back(1'b0);
        tick(1'b1, 1'b1);  expect_s(K_TDOEN, 8'd0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        // BYPASS now holds 1; Capture-DR must clear it
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);  tq.push_back(1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // IDCODE: tdo follows dr_tdo[0] only in Shift-DR
        ir_scan(8'h02, 4'b0001, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);  dr_tdo = 4'b0001;  tq.push_back(1'b1);
        tick(1'b0, 1'b0);  dr_tdo = 4'b1110;  tq.push_back(1'b0);
        tick(1'b1, 1'b0);                     // Exit1-DR
        tick(1'b0, 1'b0);  dr_tdo = 4'b0001;  // Pause-DR
        expect_s(K_TDOEN, 8'd0);
        expect_s(K_TDO, 8'd0);
        tick(1'b0, 1'b0);
        expect_s(K_TDO, 8'd0);
        tick(1'b1, 1'b0);                     // Exit2-DR
        tick(1'b0, 1'b0);  tq.push_back(1'b1); // back to Shift-DR
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);  expect_s(K_UPDDR, 8'd1);
        tick(1'b0, 1'b0);  dr_tdo = 4'b1110;

        // trst during Shift-IR after 4 bits
        ir_scan(8'h04, 4'b0100, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);  tq.push_back(cap_pat[0]);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            tq.push_back(cap_pat[i+1]);
        end
        tick(1'b0, 1'b0);
        trst = 1'b0;
        expect_s(K_TLR, 8'd1);
        expect_s(K_IR, 8'h02);
        expect_s(K_SEL, 8'h01);
        expect_s(K_TDOEN, 8'd0);
        tick(1'b0, 1'b0);
        trst = 1'b1;
        expect_s(K_RTI, 8'd1);
        expect_s(K_IR, 8'h02);
        cur_ir  = 8'h02;
        cur_sel = 4'b0001;
        ir_scan(8'h08, 4'b1000, 1'b0);

        // Drain and confirm every expectation was consumed
        repeat (4) tick(1'b0, 1'b0);
        @(negedge tck);
        #2;
        checks++;
        if (sq.size() != 0) begin
            failures++;
            $display("FAIL status_queue_drain actual=%0d pending required=0", sq.size());
        end
        checks++;
        if (tq.size() != 0) begin
            failures++;
            $display("FAIL tdo_queue_drain actual=%0d pending required=0", tq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ir_ctrl.md
# jtag_tap_ir_ctrl

Parametrised JTAG TAP front end. It combines the 16-state TAP controller, an N-bit instruction register (IR), instruction decode into one-hot data-register (DR) selects, a built-in BYPASS register and the TDO mux. It sits between the chip-level JTAG pins and the DR blocks (IDCODE, debug, boundary scan). Everything runs in the single `tck` domain; any negedge TDO retiming is done at the pad level, outside this block.

## Interface
Parameters:
- `IR_WIDTH`, 8: instruction register width, minimum 2.
- `NUM_DR`, 4: number of external data registers.
- `DR_OPCODES`, {8'h08, 8'h04, 8'h03, 8'h02}: packed `NUM_DR*IR_WIDTH` opcode table; slice i selects DR i.
- `IDCODE_INDEX`, 0: DR index loaded on reset. Its opcode is the reset instruction.
- `CAPTURE_PATTERN`, 8'b1111_0101: loaded into the IR shifter in Capture-IR. Bits [1:0] must be 2'b01.

Ports:
- `tck` in 1: the TCK clock; the only clock.
- `trst` in 1: synchronous, active-low reset.
- `tms` in 1: test mode select.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `tdo_en` out 1: high in Shift-IR and Shift-DR only.
- `dr_tdo` in NUM_DR: serial outputs from the external DRs, LSB-first.
- `dr_sel` out NUM_DR: one-hot select, or all-zero when BYPASS is selected.
- `bypass_sel` out 1: the current instruction matches no table entry.
- `ir_q` out IR_WIDTH: the latched (active) instruction.
- `st_tlr`, `st_capture_dr`, `st_shift_dr`, `st_update_dr`, `st_run_idle` out 1 each: decoded current-state strobes for the DRs.

## Operation
- TAP FSM implements the IEEE 1149.1 states and transitions, sampled on `tms` at posedge `tck`.
  - TLR: tms=0 goes to RTI.
  - RTI: tms=1 goes to Select-DR.
  - Select-DR: tms=1 goes to Select-IR, tms=0 goes to Capture-DR.
  - Select-IR: tms=1 goes to TLR, tms=0 goes to Capture-IR.
  - Capture-xR: tms=0 goes to Shift-xR, tms=1 goes to Exit1.
  - Shift-xR: holds on tms=0, tms=1 goes to Exit1.
  - Exit1: tms=1 goes to Update, tms=0 goes to Pause.
  - Pause: holds on tms=0, tms=1 goes to Exit2.
  - Exit2: tms=1 goes to Update, tms=0 goes back to Shift.
  - Update: tms=1 goes to Select-DR, tms=0 goes to RTI.
- Five consecutive tms=1 cycles reach TLR from any state.
- IR shifter, per clock edge:
  - In Capture-IR it loads `CAPTURE_PATTERN`.
  - In Shift-IR it loads `{tdi, sh[IR_WIDTH-1:1]}`.
  - Otherwise it holds.
- `ir_q` loads from the shifter on the edge that leaves Update-IR. This is the single-clock replacement for the old negedge latch.
- Decode: `ir_q` is compared against every `DR_OPCODES` slice.
  - On a match, `dr_sel` is one-hot at the lowest matching index.
  - With no match, `dr_sel` is 0 and `bypass_sel` is 1.
  - Decode outputs are registered and update together with `ir_q`.
- BYPASS register: clears to 0 in Capture-DR and loads `tdi` in Shift-DR while `bypass_sel` is high.
- TDO mux (combinational from registered state and `dr_tdo`):
  - Shift-IR: `sh[0]`.
  - Shift-DR: the selected `dr_tdo[i]`, or the BYPASS bit.
  - Elsewhere: 0.

## Timing
- Reset (trst=0 at a posedge, or FSM in TLR at a posedge):
  - State goes to TLR and the shifter to 0.
  - `ir_q` goes to `DR_OPCODES[IDCODE_INDEX]`, `dr_sel` to 1<<IDCODE_INDEX, `bypass_sel` to 0.
  - BYPASS goes to 0, `tdo` and `tdo_en` to 0.
  - Strobe outputs follow the state, so `st_tlr`=1.
- Reset asserted mid-scan: the shift is abandoned and the partially shifted value never reaches `ir_q`.
- Timing of state outputs:
  - `st_*` and `tdo_en` are valid the cycle the FSM is in the named state.
  - `tdo` shows bit 0 of the shifter in the first Shift-IR cycle, then the next bit after each Shift-IR edge.
- Latency:
  - Update-IR is entered at edge k; `ir_q`, `dr_sel` and `bypass_sel` change at edge k+1.
  - A new instruction therefore governs the first Capture-DR after it.
- Pause/Exit2 cycles preserve shifter contents; no shift happens outside Shift-xR.
- If `DR_OPCODES` contains duplicate opcodes, the lower index wins.

## Structure
- Package `jtag_pkg`:
  - `tap_state_t` enum (4-bit, standard IEEE encoding).
  - Default capture pattern constant.
  - Default opcode constants (IDCODE=8'h02).
- Sub-module `jtag_tap_fsm`: the state register, next-state logic and decoded strobes. Everything else lives in `jtag_tap_ir_ctrl`.

## Test plan
- trst=0 for 1 edge, then release -> state TLR, `ir_q`=8'h02, `dr_sel`=4'b0001, `tdo_en`=0.
- From RTI mid-scan, apply 5× tms=1 -> TLR reached on the 5th edge with no `ir_q` change other than the reset value.
- IR scan shifting 8'h03 LSB-first:
  - `tdo` sequence is 1,0,1,0,1,1,1,1 (from 8'hF5).
  - After Update-IR, `dr_sel`=4'b0010 exactly one edge later.
- Load opcode 8'hFF -> `bypass_sel`=1 and `dr_sel`=0. A DR scan of tdi=1,0,1 gives tdo=0,1,0 (one-bit delay, captured 0 first).
- IDCODE selected with `dr_tdo[0]` driven by the bench -> `tdo` mirrors it only in Shift-DR, and stays 0 and `tdo_en`=0 in Pause-DR.
- Cross-checks:
  - trst=0 asserted during Shift-IR after 4 bits -> `ir_q` returns to 8'h02 and TLR.
  - A following full IR scan behaves normally.
